// File: rtl/map_discrete_if.sv
// CPU/PPU bus, save-state port and decoded address outputs of the discrete mapper.
// master drives the bus side, slave is the mapper core.
interface map_discrete_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic [7:0]  rom_dat;
  logic [13:0] ppu_addr;
  logic        cfg_mir_v;
  logic        ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;
  logic [7:0]  ss_rdat;
  logic [21:0] prg_addr;
  logic [19:0] chr_addr;
  logic        chr_ce;
  logic        ciram_a10;
  logic [7:0]  latch_q;

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, rom_dat, ppu_addr, cfg_mir_v,
           ss_act, ss_we, ss_addr,
    input  ss_rdat, prg_addr, chr_addr, chr_ce, ciram_a10, latch_q
  );

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, rom_dat, ppu_addr, cfg_mir_v,
           ss_act, ss_we, ss_addr,
    output ss_rdat, prg_addr, chr_addr, chr_ce, ciram_a10, latch_q
  );
endinterface

// File: rtl/map_discrete.sv
// Single 8-bit latch at $8000-$FFFF banking PRG/CHR for CNROM, UxROM, GNROM,
// AxROM and ColorDreams boards, with optional bus conflicts, RMW filter and CHR lock.
module map_discrete #(
  parameter int unsigned MODE      = 0,
  parameter int unsigned PRG_BW    = 4,
  parameter int unsigned CHR_BW    = 4,
  parameter bit          BUS_CONF  = 1'b0,
  parameter bit          WR_FILTER = 1'b0,
  parameter bit          CHR_LOCK  = 1'b0,
  parameter logic [1:0]  LOCK_CODE = 2'b01
) (
  input  logic         m2,
  input  logic         rst_n,
  map_discrete_if.slave bus
);

  localparam logic [7:0] PRG_MASK = 8'((9'd1 << PRG_BW) - 9'd1);
  localparam logic [7:0] CHR_MASK = 8'((9'd1 << CHR_BW) - 9'd1);
  localparam logic [2:0] MODE_ID  = 3'(MODE);
  localparam bit         LOCK_EN  = CHR_LOCK && (MODE == 0);

  logic [7:0]  r_latch;
  logic        r_wr_prev;
  logic [7:0]  w_wd;
  logic        w_cpu_wr;
  logic [7:0]  w_ux_bank;
  logic [21:0] w_prg_addr;
  logic [19:0] w_chr_addr;
  logic        w_ciram_a10;
  logic        w_lock_ok;
  logic [7:0]  w_ss_rdat;

  assign w_wd     = BUS_CONF ? (bus.cpu_dat & bus.rom_dat) : bus.cpu_dat;
  assign w_cpu_wr = bus.cpu_addr[15] && !bus.cpu_rw && !(WR_FILTER && r_wr_prev);

  // The save-state port owns the latch while active; CPU cycles are ignored then.
  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      r_latch   <= '0;
      r_wr_prev <= 1'b0;
    end else if (bus.ss_act) begin
      if (bus.ss_we && bus.ss_addr == 8'd0) r_latch   <= bus.cpu_dat;
      if (bus.ss_we && bus.ss_addr == 8'd1) r_wr_prev <= bus.cpu_dat[0];
    end else begin
      r_wr_prev <= !bus.cpu_rw;
      if (w_cpu_wr) r_latch <= w_wd;
    end
  end

  always_comb begin
    w_ux_bank   = '0;
    w_prg_addr  = {7'd0, bus.cpu_addr[14:0]};
    w_chr_addr  = {7'd0, bus.ppu_addr[12:0]};
    w_ciram_a10 = bus.cfg_mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11];
    case (MODE)
      1: begin
        w_ux_bank  = bus.cpu_addr[14] ? PRG_MASK : (r_latch & PRG_MASK);
        w_prg_addr = {w_ux_bank, bus.cpu_addr[13:0]};
      end
      2: begin
        w_prg_addr = {5'd0, r_latch[5:4], bus.cpu_addr[14:0]};
        w_chr_addr = {5'd0, r_latch[1:0], bus.ppu_addr[12:0]};
      end
      3: begin
        w_prg_addr  = {4'd0, r_latch[2:0], bus.cpu_addr[14:0]};
        w_ciram_a10 = r_latch[4];
      end
      4: begin
        w_prg_addr = {5'd0, r_latch[1:0], bus.cpu_addr[14:0]};
        w_chr_addr = {3'd0, r_latch[7:4], bus.ppu_addr[12:0]};
      end
      default: begin
        // An 8-bit CHR bank would reach bit 20; the top bit falls off the 1 MiB space.
        w_chr_addr = 20'({r_latch & CHR_MASK, bus.ppu_addr[12:0]});
      end
    endcase
  end

  assign w_lock_ok = !LOCK_EN || (r_latch[5:4] == LOCK_CODE);

  always_comb begin
    w_ss_rdat = 8'hFF;
    case (bus.ss_addr)
      8'd0:    w_ss_rdat = r_latch;
      8'd1:    w_ss_rdat = {7'd0, r_wr_prev};
      8'd127:  w_ss_rdat = {5'd0, MODE_ID};
      default: w_ss_rdat = 8'hFF;
    endcase
  end

  assign bus.prg_addr  = w_prg_addr;
  assign bus.chr_addr  = w_chr_addr;
  assign bus.chr_ce    = !bus.ppu_addr[13] && w_lock_ok;
  assign bus.ciram_a10 = w_ciram_a10;
  assign bus.latch_q   = r_latch;
  assign bus.ss_rdat   = w_ss_rdat;

endmodule
